pong_paddle_tracker: RTL and testbench

- Consumes the 16-bit paddle-1 target Y written by software into the paddle-Y output register (its out_port).
- Clamps the target to the playfield, then slews the displayed paddle toward it at a bounded rate, updating once per video frame.
- Emits a registered per-pixel "paddle here" flag to the VGA pixel mixer, plus status bits for the game logic.

---
 rtl/pong_paddle_tracker.sv | 164 ++++++++++++++++
 tb/tb_pong_paddle_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_paddle_tracker.sv
// pong_paddle_tracker
// Tracks the software-requested paddle-1 top Y. Once per video frame the
// target is sampled and clamped to the playfield, then the displayed
// paddle slews toward it by at most MAX_STEP lines. A registered per-pixel
// hit flag feeds the VGA mixer; moving/at_limit report status to game logic.
module pong_paddle_tracker #(
  parameter logic [15:0] SCREEN_H = 16'd480,
  parameter logic [15:0] PADDLE_H = 16'd64,
  parameter logic [15:0] PADDLE_W = 16'd8,
  parameter logic [15:0] PADDLE_X = 16'd16,
  parameter logic [15:0] MAX_STEP = 16'd4,
  parameter logic [15:0] DEADBAND = 16'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] target_y,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic [15:0] paddle_y,
  output logic        paddle_hit,
  output logic        moving,
  output logic        at_limit
);

  // Lowest legal top-of-paddle line, and the centred start position.
  localparam logic [15:0] YMAX    = SCREEN_H - PADDLE_H;
  localparam logic [15:0] Y_RESET = YMAX >> 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] paddle_y_q, paddle_y_d;
  logic        moving_q, moving_d;
  logic        at_limit_q, at_limit_d;
  logic        hit_q, hit_d;

  logic        tgt_above_s;
  logic [16:0] tgt_ext_s;
  logic [16:0] pos_ext_s;
  logic [16:0] diff_s;
  logic [16:0] step_s;
  logic [16:0] moved_s;
  logic [15:0] clamped_s;

  logic [16:0] px_ext_s;
  logic [16:0] py_ext_s;
  logic [16:0] x_end_s;
  logic [16:0] y_end_s;
  logic        in_x_s;
  logic        in_y_s;

  // Clamp the raw target and compute the bounded step toward the stored target.
  // The distance is taken as a non-negative magnitude in 17 bits so it cannot
  // wrap; the step is limited to the distance, so the paddle never overshoots.
  always_comb begin
    if (target_y > YMAX) begin
      clamped_s = YMAX;
    end else begin
      clamped_s = target_y;
    end
    tgt_ext_s   = {1'b0, tgt_q};
    pos_ext_s   = {1'b0, paddle_y_q};
    tgt_above_s = (tgt_q > paddle_y_q);
    if (tgt_above_s) begin
      diff_s = tgt_ext_s - pos_ext_s;
    end else begin
      diff_s = pos_ext_s - tgt_ext_s;
    end
    if (diff_s > {1'b0, MAX_STEP}) begin
      step_s = {1'b0, MAX_STEP};
    end else begin
      step_s = diff_s;
    end
    if (tgt_above_s) begin
      moved_s = pos_ext_s + step_s;
    end else begin
      moved_s = pos_ext_s - step_s;
    end
  end

  // Frame-update FSM next-state: sample the target, then apply one step.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    paddle_y_d = paddle_y_q;
    moving_d   = moving_q;
    at_limit_d = at_limit_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        tgt_d   = clamped_s;
        state_d = ST_STEP;
      end
      ST_STEP: begin
        if (diff_s <= {1'b0, DEADBAND}) begin
          paddle_y_d = paddle_y_q;
          moving_d   = 1'b0;
        end else begin
          paddle_y_d = moved_s[15:0];
          moving_d   = 1'b1;
        end
        at_limit_d = (paddle_y_d == 16'd0) || (paddle_y_d == YMAX);
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pixel hit test against the paddle position registered at cycle start.
  // Coordinates are widened so the end-of-box sums cannot wrap.
  always_comb begin
    px_ext_s = {6'd0, pixel_x};
    py_ext_s = {6'd0, pixel_y};
    x_end_s  = {1'b0, PADDLE_X} + {1'b0, PADDLE_W};
    y_end_s  = {1'b0, paddle_y_q} + {1'b0, PADDLE_H};
    in_x_s   = (px_ext_s >= {1'b0, PADDLE_X}) && (px_ext_s < x_end_s);
    in_y_s   = (py_ext_s >= {1'b0, paddle_y_q}) && (py_ext_s < y_end_s);
    if (pixel_valid && in_x_s && in_y_s) begin
      hit_d = 1'b1;
    end else begin
      hit_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any update in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tgt_q      <= Y_RESET;
      paddle_y_q <= Y_RESET;
      moving_q   <= 1'b0;
      at_limit_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      paddle_y_q <= paddle_y_d;
      moving_q   <= moving_d;
      at_limit_q <= at_limit_d;
      hit_q      <= hit_d;
    end
  end

  assign paddle_y   = paddle_y_q;
  assign paddle_hit = hit_q;
  assign moving     = moving_q;
  assign at_limit   = at_limit_q;

endmodule

// File: tb/tb_pong_paddle_tracker.sv
// Directed self-checking bench for pong_paddle_tracker.
module tb_pong_paddle_tracker;

  logic        clk;
  logic        reset_n;
  logic [15:0] target_y;
  logic        frame_start;
  logic        pixel_valid;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [15:0] paddle_y;
  logic        paddle_hit;
  logic        moving;
  logic        at_limit;

  int checks;
  int fails;

  pong_paddle_tracker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .target_y   (target_y),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .paddle_y   (paddle_y),
    .paddle_hit (paddle_hit),
    .moving     (moving),
    .at_limit   (at_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame_start pulse; returns just after the edge that applies the step.
  task automatic do_frame(input int gap);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  // Reference for one frame update (tgt already clamped).
  function automatic logic [15:0] next_pos(input logic [15:0] cur, input logic [15:0] tgt);
    int d;
    int s;
    d = (tgt > cur) ? int'(tgt) - int'(cur) : int'(cur) - int'(tgt);
    if (d <= 1) return cur;
    s = (d > 4) ? 4 : d;
    return (tgt > cur) ? 16'(int'(cur) + s) : 16'(int'(cur) - s);
  endfunction

  task automatic test_reset();
    checks++; if (paddle_y !== 16'd208) begin fails++; $display("FAIL reset_paddle_y got %0d want 208", paddle_y); end
    checks++; if (paddle_hit !== 1'b0) begin fails++; $display("FAIL reset_hit got %0b want 0", paddle_hit); end
    checks++; if (moving !== 1'b0) begin fails++; $display("FAIL reset_moving got %0b want 0", moving); end
    checks++; if (at_limit !== 1'b0) begin fails++; $display("FAIL reset_at_limit got %0b want 0", at_limit); end
    // Move once so the reset value differs from the current one.
    target_y = 16'd0;
    do_frame(2);
    checks++; if (paddle_y !== 16'd204) begin fails++; $display("FAIL pre_reset_step got %0d want 204", paddle_y); end
    pixel_valid = 1'b1; pixel_x = 11'd16; pixel_y = 11'd210;
    tick();
    checks++; if (paddle_hit !== 1'b1) begin fails++; $display("FAIL pre_reset_hit got %0b want 1", paddle_hit); end
    // Reset while the FSM is in STEP.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    checks++; if (paddle_y !== 16'd208) begin fails++; $display("FAIL midstep_reset_y got %0d want 208", paddle_y); end
    checks++; if (paddle_hit !== 1'b0) begin fails++; $display("FAIL midstep_reset_hit got %0b want 0", paddle_hit); end
    checks++; if (moving !== 1'b0) begin fails++; $display("FAIL midstep_reset_moving got %0b want 0", moving); end
    pixel_valid = 1'b0;
    reset_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (paddle_y !== 16'd208) begin fails++; $display("FAIL post_reset_idle_y got %0d want 208", paddle_y); end
    checks++; if (moving !== 1'b0) begin fails++; $display("FAIL post_reset_idle_moving got %0b want 0", moving); end
  endtask

  task automatic test_slew_down();
    logic [15:0] exp_y [4];
    logic        exp_m [4];
    exp_y = '{16'd212, 16'd216, 16'd220, 16'd220};
    exp_m = '{1'b1, 1'b1, 1'b1, 1'b0};
    target_y = 16'd220;
    for (int k = 0; k < 4; k++) begin
      do_frame(97);
      checks++; if (paddle_y !== exp_y[k]) begin fails++; $display("FAIL slew_y[%0d] got %0d want %0d", k, paddle_y, exp_y[k]); end
      checks++; if (moving !== exp_m[k]) begin fails++; $display("FAIL slew_moving[%0d] got %0b want %0b", k, moving, exp_m[k]); end
    end
  endtask

  task automatic test_deadband_clamp();
    int exp;
    apply_reset();
    target_y = 16'd209;
    do_frame(2);
    checks++; if (paddle_y !== 16'd208) begin fails++; $display("FAIL deadband_up_y got %0d want 208", paddle_y); end
    checks++; if (moving !== 1'b0) begin fails++; $display("FAIL deadband_up_moving got %0b want 0", moving); end
    target_y = 16'd207;
    do_frame(2);
    checks++; if (paddle_y !== 16'd208) begin fails++; $display("FAIL deadband_dn_y got %0d want 208", paddle_y); end
    target_y = 16'hFFFF;
    for (int k = 1; k <= 60; k++) begin
      do_frame(2);
      exp = 208 + 4 * k;
      if (exp > 416) exp = 416;
      checks++; if (paddle_y !== 16'(exp)) begin fails++; $display("FAIL clamp_y[%0d] got %0d want %0d", k, paddle_y, exp); end
    end
    checks++; if (at_limit !== 1'b1) begin fails++; $display("FAIL clamp_at_limit got %0b want 1", at_limit); end
    checks++; if (moving !== 1'b0) begin fails++; $display("FAIL clamp_moving got %0b want 0", moving); end
  endtask

  task automatic test_upward_clamp();
    logic [15:0] exp;
    exp = 16'd416;
    target_y = 16'd2;
    for (int k = 0; k < 200 && exp != 16'd2; k++) begin
      do_frame(1);
      exp = next_pos(exp, 16'd2);
    end
    checks++; if (paddle_y !== 16'd2) begin fails++; $display("FAIL reach_2_y got %0d want 2", paddle_y); end
    checks++; if (at_limit !== 1'b0) begin fails++; $display("FAIL at_2_at_limit got %0b want 0", at_limit); end
    target_y = 16'd0;
    do_frame(2);
    checks++; if (paddle_y !== 16'd0) begin fails++; $display("FAIL top_y got %0d want 0", paddle_y); end
    checks++; if (at_limit !== 1'b1) begin fails++; $display("FAIL top_at_limit got %0b want 1", at_limit); end
    target_y = 16'd3;
    do_frame(2);
    checks++; if (paddle_y !== 16'd3) begin fails++; $display("FAIL fine_step_y got %0d want 3", paddle_y); end
    checks++; if (moving !== 1'b1) begin fails++; $display("FAIL fine_step_moving got %0b want 1", moving); end
    checks++; if (at_limit !== 1'b0) begin fails++; $display("FAIL fine_step_at_limit got %0b want 0", at_limit); end
  endtask

  task automatic test_pixel_hit();
    logic [10:0] vx [7];
    logic [10:0] vy [7];
    logic        vv [7];
    logic        vh [7];
    target_y = 16'd0;
    do_frame(1);
    target_y = 16'd100;
    for (int k = 0; k < 40 && paddle_y != 16'd100; k++) do_frame(1);
    checks++; if (paddle_y !== 16'd100) begin fails++; $display("FAIL reach_100_y got %0d want 100", paddle_y); end
    vx = '{11'd16, 11'd23, 11'd24, 11'd16, 11'd16, 11'd16, 11'd15};
    vy = '{11'd100, 11'd163, 11'd100, 11'd99, 11'd164, 11'd120, 11'd100};
    vv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vh = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      pixel_valid = vv[k]; pixel_x = vx[k]; pixel_y = vy[k];
      tick();
      checks++; if (paddle_hit !== vh[k]) begin fails++; $display("FAIL hit(%0d,%0d,v=%0b) got %0b want %0b", vx[k], vy[k], vv[k], paddle_hit, vh[k]); end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_update_vs_pixel();
    target_y = 16'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    pixel_valid = 1'b1; pixel_x = 11'd16; pixel_y = 11'd163;
    tick();
    checks++; if (paddle_y !== 16'd96) begin fails++; $display("FAIL same_cycle_y got %0d want 96", paddle_y); end
    checks++; if (paddle_hit !== 1'b1) begin fails++; $display("FAIL same_cycle_hit_old_y got %0b want 1", paddle_hit); end
    tick();
    checks++; if (paddle_hit !== 1'b0) begin fails++; $display("FAIL next_cycle_hit_new_y got %0b want 0", paddle_hit); end
    pixel_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    target_y = 16'd50;
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    target_y = 16'd300;
    tick();
    checks++; if (paddle_y !== 16'd92) begin fails++; $display("FAIL b2b_step_y got %0d want 92", paddle_y); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (paddle_y !== 16'd92) begin fails++; $display("FAIL b2b_single_step_y got %0d want 92", paddle_y); end
    checks++; if (moving !== 1'b1) begin fails++; $display("FAIL b2b_moving got %0b want 1", moving); end
  endtask

  initial begin
    checks      = 0;
    fails       = 0;
    reset_n     = 1'b0;
    target_y    = 16'd0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_x     = 11'd0;
    pixel_y     = 11'd0;
    #12;
    reset_n = 1'b1;
    tick();
    test_reset();
    test_slew_down();
    test_deadband_clamp();
    test_upward_clamp();
    test_pixel_hit();
    test_update_vs_pixel();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
